// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control definitions: forwarding select codes, hazard FSM states
// and the PC register index.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_PC  = 4'd15;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-register observation and control bundle between the core and the hazard unit.
// stall_count exists only when HAZARD_STALL_COUNTER_EN is defined.
interface hazard_stall_unit_if #(
    parameter int REG_ADDR_W = 4
);
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic [REG_ADDR_W-1:0] id_rd_src;
    logic                  id_use_rn;
    logic                  id_use_rm;
    logic                  id_use_rd;
    logic                  id_branch_taken;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;

    logic                  pc_enable;
    logic                  if_id_enable;
    logic                  if_id_flush;
    logic                  nop_insert;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [1:0]            fwd_c_sel;
`ifdef HAZARD_STALL_COUNTER_EN
    logic [15:0]           stall_count;
`endif

    modport master (
`ifdef HAZARD_STALL_COUNTER_EN
        input  stall_count,
`endif
        output id_rn, id_rm, id_rd_src, id_use_rn, id_use_rm, id_use_rd, id_branch_taken,
        output ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        input  pc_enable, if_id_enable, if_id_flush, nop_insert,
        input  fwd_a_sel, fwd_b_sel, fwd_c_sel
    );

    modport slave (
`ifdef HAZARD_STALL_COUNTER_EN
        output stall_count,
`endif
        input  id_rn, id_rm, id_rd_src, id_use_rn, id_use_rm, id_use_rd, id_branch_taken,
        input  ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        output pc_enable, if_id_enable, if_id_flush, nop_insert,
        output fwd_a_sel, fwd_b_sel, fwd_c_sel
    );

endinterface

// File: rtl/hazard_stall_unit_fwd_select.sv
// Combinational operand-forwarding select for one ID source register.
// Youngest producer wins; a load in EX is never a forwarding source.
module fwd_select
    import core_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_use,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_wb_reg_write,
    output logic [1:0]            o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_use && (i_src != REG_ADDR_W'(REG_PC))) begin
            if (i_ex_reg_write && !i_ex_mem_read && (i_ex_rd == i_src))
                o_sel = FWD_EX;
            else if (i_mem_reg_write && (i_mem_rd == i_src))
                o_sel = FWD_MEM;
            else if (i_wb_reg_write && (i_wb_rd == i_src))
                o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, branch flush and operand forwarding control beside the ID stage.
// Optional macro HAZARD_STALL_COUNTER_EN adds a saturating bubble-cycle counter.
//
//   state | meaning
//   RUN   | normal flow; a load-use hazard here is the first bubble cycle
//   STALL | remaining bubble cycles; hazard detection suspended
module hazard_stall_unit
    import core_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int REG_ADDR_W     = 4
) (
    input logic               clk,
    input logic               reset,
    hazard_stall_unit_if.slave hz
);

    hz_state_t  r_state;
    logic [1:0] r_stall_cnt;
    logic       w_load_use;
    logic       w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] w_fwd_c;

    assign w_load_use = hz.ex_mem_read && hz.ex_reg_write
                     && (hz.ex_rd != REG_ADDR_W'(REG_PC))
                     && ((hz.id_use_rn && (hz.ex_rd == hz.id_rn))
                      || (hz.id_use_rm && (hz.ex_rd == hz.id_rm))
                      || (hz.id_use_rd && (hz.ex_rd == hz.id_rd_src)));

    assign w_stall = (r_state == STALL) || w_load_use;

    // r_stall_cnt counts bubbles still owed after the current one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_stall_cnt <= 2'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_load_use) begin
                        r_stall_cnt <= 2'(LOAD_USE_STALL - 1);
                        r_state     <= (LOAD_USE_STALL > 1) ? STALL : RUN;
                    end
                end
                STALL: begin
                    if (r_stall_cnt <= 2'd1) begin
                        r_stall_cnt <= 2'd0;
                        r_state     <= RUN;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_stall_cnt <= 2'd0;
                end
            endcase
        end
    end

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .i_src(hz.id_rn), .i_use(hz.id_use_rn),
        .i_ex_rd(hz.ex_rd), .i_ex_reg_write(hz.ex_reg_write), .i_ex_mem_read(hz.ex_mem_read),
        .i_mem_rd(hz.mem_rd), .i_mem_reg_write(hz.mem_reg_write),
        .i_wb_rd(hz.wb_rd), .i_wb_reg_write(hz.wb_reg_write),
        .o_sel(w_fwd_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .i_src(hz.id_rm), .i_use(hz.id_use_rm),
        .i_ex_rd(hz.ex_rd), .i_ex_reg_write(hz.ex_reg_write), .i_ex_mem_read(hz.ex_mem_read),
        .i_mem_rd(hz.mem_rd), .i_mem_reg_write(hz.mem_reg_write),
        .i_wb_rd(hz.wb_rd), .i_wb_reg_write(hz.wb_reg_write),
        .o_sel(w_fwd_b)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_c (
        .i_src(hz.id_rd_src), .i_use(hz.id_use_rd),
        .i_ex_rd(hz.ex_rd), .i_ex_reg_write(hz.ex_reg_write), .i_ex_mem_read(hz.ex_mem_read),
        .i_mem_rd(hz.mem_rd), .i_mem_reg_write(hz.mem_reg_write),
        .i_wb_rd(hz.wb_rd), .i_wb_reg_write(hz.wb_reg_write),
        .o_sel(w_fwd_c)
    );

    // Outputs react in the detecting cycle; reset forces the pass-through values
    assign hz.pc_enable    = reset || !w_stall;
    assign hz.if_id_enable = reset || !w_stall;
    assign hz.nop_insert   = !reset && w_stall;
    assign hz.if_id_flush  = !reset && hz.id_branch_taken && !w_stall;
    assign hz.fwd_a_sel    = reset ? FWD_RF : w_fwd_a;
    assign hz.fwd_b_sel    = reset ? FWD_RF : w_fwd_b;
    assign hz.fwd_c_sel    = reset ? FWD_RF : w_fwd_c;

`ifdef HAZARD_STALL_COUNTER_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_count <= 16'd0;
        else if (w_stall && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'd1;
    end

    assign hz.stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (1 and 3 bubble cycles) driven in lockstep,
// checked by a vector table, directed corner sequences and a random run against a model.
module tb_hazard_stall_unit;
    import core_pkg::*;

    typedef struct {
        logic [3:0] rn, rm, rds;
        logic       urn, urm, urd, br;
        logic [3:0] exrd;
        logic       exw, exl;
        logic [3:0] memrd;
        logic       memw;
        logic [3:0] wbrd;
        logic       wbw;
        logic       rst;
    } in_t;

    typedef struct {
        in_t        i;
        logic [9:0] exp1;
    } vec_t;

    // Output vector layout: {pc_en, if_id_en, flush, nop, fwd_a, fwd_b, fwd_c}
    localparam logic [9:0] RESET_OUT = 10'b11_0_0_00_00_00;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.REG_ADDR_W(4)) if1 ();
    hazard_stall_unit_if #(.REG_ADDR_W(4)) if3 ();

    hazard_stall_unit #(.LOAD_USE_STALL(1), .REG_ADDR_W(4)) dut1 (.clk(clk), .reset(reset), .hz(if1));
    hazard_stall_unit #(.LOAD_USE_STALL(3), .REG_ADDR_W(4)) dut3 (.clk(clk), .reset(reset), .hz(if3));

    int tests = 0;
    int fails = 0;
    int left1 = 0, left3 = 0;
    logic [15:0] cnt1 = 16'd0, cnt3 = 16'd0;
    logic [9:0] out1, out3;

    function automatic in_t idle();
        in_t v;
        v = '{rn: 4'd0, rm: 4'd0, rds: 4'd0, urn: 1'b0, urm: 1'b0, urd: 1'b0, br: 1'b0,
              exrd: 4'd0, exw: 1'b0, exl: 1'b0, memrd: 4'd0, memw: 1'b0,
              wbrd: 4'd0, wbw: 1'b0, rst: 1'b0};
        return v;
    endfunction

    function automatic in_t load_use(input logic [3:0] r);
        in_t v;
        v = idle();
        v.rn = r; v.urn = 1'b1; v.exrd = r; v.exw = 1'b1; v.exl = 1'b1;
        return v;
    endfunction

    // Youngest writing producer wins; the load in EX and R15 never forward.
    function automatic logic [1:0] m_fwd(input logic [3:0] src, input logic use_f, input in_t v);
        logic [3:0] rd [3];
        logic       ok [3];
        m_fwd = 2'd0;
        rd[0] = v.exrd;  ok[0] = v.exw && !v.exl;
        rd[1] = v.memrd; ok[1] = v.memw;
        rd[2] = v.wbrd;  ok[2] = v.wbw;
        if (use_f && src != 4'd15)
            for (int s = 2; s >= 0; s--)
                if (ok[s] && rd[s] == src) m_fwd = 2'(s + 1);
    endfunction

    function automatic logic m_lu(input in_t v);
        return v.exl && v.exw && v.exrd != 4'd15 &&
               ((v.urn && v.rn == v.exrd) || (v.urm && v.rm == v.exrd) || (v.urd && v.rds == v.exrd));
    endfunction

    function automatic logic [9:0] m_out(input in_t v, input int left);
        logic st;
        if (v.rst) return RESET_OUT;
        st = (left > 0) || m_lu(v);
        return {~st, ~st, v.br & ~st, st,
                m_fwd(v.rn, v.urn, v), m_fwd(v.rm, v.urm, v), m_fwd(v.rds, v.urd, v)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        reset = v.rst;
        if1.id_rn = v.rn;   if3.id_rn = v.rn;
        if1.id_rm = v.rm;   if3.id_rm = v.rm;
        if1.id_rd_src = v.rds; if3.id_rd_src = v.rds;
        if1.id_use_rn = v.urn; if3.id_use_rn = v.urn;
        if1.id_use_rm = v.urm; if3.id_use_rm = v.urm;
        if1.id_use_rd = v.urd; if3.id_use_rd = v.urd;
        if1.id_branch_taken = v.br; if3.id_branch_taken = v.br;
        if1.ex_rd = v.exrd; if3.ex_rd = v.exrd;
        if1.ex_reg_write = v.exw; if3.ex_reg_write = v.exw;
        if1.ex_mem_read = v.exl;  if3.ex_mem_read = v.exl;
        if1.mem_rd = v.memrd; if3.mem_rd = v.memrd;
        if1.mem_reg_write = v.memw; if3.mem_reg_write = v.memw;
        if1.wb_rd = v.wbrd; if3.wb_rd = v.wbrd;
        if1.wb_reg_write = v.wbw; if3.wb_reg_write = v.wbw;
    endtask

    // One pipeline cycle: drive after negedge, check mid-cycle, advance the model for the posedge.
    task automatic cycle(input string name, input in_t v);
        logic [9:0] e1, e3;
        @(negedge clk);
        drive(v);
        #1;
        out1 = {if1.pc_enable, if1.if_id_enable, if1.if_id_flush, if1.nop_insert,
                if1.fwd_a_sel, if1.fwd_b_sel, if1.fwd_c_sel};
        out3 = {if3.pc_enable, if3.if_id_enable, if3.if_id_flush, if3.nop_insert,
                if3.fwd_a_sel, if3.fwd_b_sel, if3.fwd_c_sel};
        e1 = m_out(v, left1);
        e3 = m_out(v, left3);
        chk({name, "/model1"}, 16'(out1), 16'(e1));
        chk({name, "/model3"}, 16'(out3), 16'(e3));
`ifdef HAZARD_STALL_COUNTER_EN
        chk({name, "/count1"}, if1.stall_count, cnt1);
        chk({name, "/count3"}, if3.stall_count, cnt3);
`endif
        if (v.rst) begin
            left1 = 0; left3 = 0; cnt1 = 16'd0; cnt3 = 16'd0;
        end else begin
            if (e1[6] && cnt1 != 16'hFFFF) cnt1 = cnt1 + 16'd1;
            if (e3[6] && cnt3 != 16'hFFFF) cnt3 = cnt3 + 16'd1;
            if (left1 > 0) left1--; else if (m_lu(v)) left1 = 0;
            if (left3 > 0) left3--; else if (m_lu(v)) left3 = 2;
        end
    endtask

    function automatic logic [3:0] rnd_reg();
        logic [3:0] pool [5];
        pool[0] = 4'd0; pool[1] = 4'd1; pool[2] = 4'd2; pool[3] = 4'd3; pool[4] = 4'd15;
        return pool[$urandom_range(0, 4)];
    endfunction

    vec_t tbl [10];
    in_t  v;

    initial begin
        v = load_use(4'd3); v.br = 1'b1; v.rst = 1'b1;
        cycle("reset0", v);
        chk("reset0/values", 16'(out1), 16'(RESET_OUT));
        cycle("reset1", v);
        cycle("idle", idle());
        chk("idle/values", 16'(out1), 16'(10'b11_0_0_00_00_00));

        // Table: each row starts from RUN in the single-bubble instance
        v = idle(); v.rm = 4'd5; v.urm = 1'b1; v.exrd = 4'd5; v.exw = 1'b1;
        v.memrd = 4'd5; v.memw = 1'b1; v.wbrd = 4'd5; v.wbw = 1'b1;
        tbl[0] = '{v, 10'b11_0_0_00_01_00};
        v.exw = 1'b0;  tbl[1] = '{v, 10'b11_0_0_00_10_00};
        v.memw = 1'b0; tbl[2] = '{v, 10'b11_0_0_00_11_00};
        v = idle(); v.rn = 4'd15; v.urn = 1'b1; v.exrd = 4'd15; v.exw = 1'b1; v.exl = 1'b1;
        tbl[3] = '{v, 10'b11_0_0_00_00_00};
        tbl[4] = '{load_use(4'd3), 10'b00_0_1_00_00_00};
        v = idle(); v.rm = 4'd7; v.urm = 1'b1; v.exrd = 4'd7; v.exw = 1'b1; v.exl = 1'b1;
        v.memrd = 4'd7; v.memw = 1'b1;
        tbl[5] = '{v, 10'b00_0_1_00_10_00};
        v = idle(); v.rds = 4'd9; v.urd = 1'b1; v.wbrd = 4'd9; v.wbw = 1'b1;
        tbl[6] = '{v, 10'b11_0_0_00_00_11};
        v = idle(); v.rn = 4'd4; v.exrd = 4'd4; v.exw = 1'b1;
        tbl[7] = '{v, 10'b11_0_0_00_00_00};
        v = idle(); v.br = 1'b1;
        tbl[8] = '{v, 10'b11_1_0_00_00_00};
        v = idle(); v.rds = 4'd2; v.urd = 1'b1; v.exrd = 4'd2; v.exw = 1'b1; v.exl = 1'b1; v.br = 1'b1;
        tbl[9] = '{v, 10'b00_0_1_00_00_00};
        for (int k = 0; k < 10; k++) begin
            cycle($sformatf("table%0d", k), tbl[k].i);
            chk($sformatf("table%0d/exp", k), 16'(out1), 16'(tbl[k].exp1));
        end

        // Single-bubble hazard then the load moves on
        for (int k = 0; k < 3; k++) cycle("drain", idle());
        cycle("lus1_hz", load_use(4'd3));
        chk("lus1_hz/nop", 16'(out1[6]), 16'd1);
        chk("lus1_hz/en", 16'(out1[9:8]), 16'd0);
        cycle("lus1_after", idle());
        chk("lus1_after/run", 16'(out1), 16'(10'b11_0_0_00_00_00));

        // Three bubbles for one load, no extra bubble afterwards
        for (int k = 0; k < 3; k++) cycle("drain", idle());
        cycle("lus3_c0", load_use(4'd3));
        chk("lus3_c0/nop_pc", 16'({out3[6], out3[9]}), 16'b10);
        for (int k = 1; k < 4; k++) begin
            cycle($sformatf("lus3_c%0d", k), idle());
            chk($sformatf("lus3_c%0d/nop_pc", k), 16'({out3[6], out3[9]}), (k < 3) ? 16'b10 : 16'b01);
        end

        // Branch masked by the stall, flushed once ID resumes
        for (int k = 0; k < 3; k++) cycle("drain", idle());
        v = load_use(4'd6); v.br = 1'b1;
        cycle("br_hz", v);
        chk("br_hz/flush_nop", 16'(out1[7:6]), 16'b01);
        v = idle(); v.br = 1'b1;
        cycle("br_resume", v);
        chk("br_resume/flush_nop", 16'(out1[7:6]), 16'b10);

        // Reset in the middle of a three-bubble stall
        for (int k = 0; k < 3; k++) cycle("drain", idle());
        cycle("rst_c0", load_use(4'd1));
        v = idle(); v.rst = 1'b1;
        cycle("rst_c1", v);
        chk("rst_c1/values", 16'(out3), 16'(RESET_OUT));
        cycle("rst_c2", idle());
        chk("rst_c2/nop", 16'(out3[6]), 16'd0);
`ifdef HAZARD_STALL_COUNTER_EN
        chk("rst_c2/count", if3.stall_count, 16'd0);
`endif
        cycle("rst_c3", idle());
        chk("rst_c3/nop", 16'(out3[6]), 16'd0);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            v.rn = rnd_reg(); v.rm = rnd_reg(); v.rds = rnd_reg();
            v.urn = 1'($urandom); v.urm = 1'($urandom); v.urd = 1'($urandom);
            v.br = 1'($urandom);
            v.exrd = rnd_reg(); v.exw = 1'($urandom); v.exl = 1'($urandom);
            v.memrd = rnd_reg(); v.memw = 1'($urandom);
            v.wbrd = rnd_reg(); v.wbw = 1'($urandom);
            v.rst = ($urandom_range(0, 49) == 0);
            cycle("random", v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
